// File: rtl/lfsr_bank.sv
// lfsr_bank: N_CH independent Fibonacci LFSRs delivering one packed random word
// per valid/ready handshake, with runtime seeding and zero-seed lockup recovery.
module lfsr_bank #(
  parameter int unsigned       WIDTH       = 16,
  parameter int unsigned       N_CH        = 4,
  parameter logic [WIDTH-1:0]  TAPS        = WIDTH'(16'hD008),
  parameter logic [WIDTH-1:0]  SEED        = WIDTH'(16'h632C),
  parameter logic [WIDTH-1:0]  SEED_STRIDE = WIDTH'(16'h9E37),
  parameter int unsigned       STEPS       = 1,
  localparam int unsigned      CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [N_CH*WIDTH-1:0]  q,
  input  logic                   seed_we,
  input  logic [CH_W-1:0]        seed_ch,
  input  logic [WIDTH-1:0]       seed_data,
  output logic                   lockup
);

  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  // Parameter sanity checks at elaboration
  if (WIDTH < 2) begin : g_chk_width
    $error("lfsr_bank: WIDTH must be >= 2");
  end
  if (N_CH < 1) begin : g_chk_nch
    $error("lfsr_bank: N_CH must be >= 1");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_chk_taps
    $error("lfsr_bank: TAPS[WIDTH-1] must be 1");
  end
  if (SEED == '0) begin : g_chk_seed
    $error("lfsr_bank: SEED must be nonzero");
  end
  if (STEPS < 1) begin : g_chk_steps
    $error("lfsr_bank: STEPS must be >= 1");
  end

  // Default seed of a channel; falls back to SEED if the stride cancels it to zero
  function automatic logic [WIDTH-1:0] ds(input int unsigned c);
    logic [WIDTH-1:0] v;
    v = SEED ^ (WIDTH'(c) * SEED_STRIDE);
    if (v == '0) v = SEED;
    return v;
  endfunction

  // One Fibonacci shift: left shift, feedback parity into bit 0
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ^(v & TAPS)};
  endfunction

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             adv;
  logic [WIDTH-1:0] d [N_CH];
  logic             seed_hit;
  logic [WIDTH-1:0] seed_val;

  // Next-state logic: HOLD presents a word, SHIFT advances STEPS times after a fire
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    adv       = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (out_valid && out_ready) begin
          state_nxt = S_SHIFT;
          cnt_nxt   = CNT_W'(STEPS);
        end else if (!en) begin
          state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        adv     = 1'b1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = en ? S_HOLD : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Seed write decode; a zero seed is replaced by the channel default
  always_comb begin
    seed_hit = seed_we && (32'(seed_ch) < N_CH);
    seed_val = (seed_data == '0) ? ds(32'(seed_ch)) : seed_data;
  end

  // State, step counter and registered valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_valid <= (state_nxt == S_HOLD);
    end
  end

  // Channel registers: seed write wins over advance; lockup flags a zero-seed repair
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < N_CH; c++) d[c] <= ds(c);
      lockup <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (seed_hit && (32'(seed_ch) == c)) d[c] <= seed_val;
        else if (adv)                        d[c] <= step(d[c]);
      end
      lockup <= seed_hit && (seed_data == '0);
    end
  end

  // Pack channel states onto q
  for (genvar c = 0; c < N_CH; c++) begin : g_q
    assign q[c*WIDTH +: WIDTH] = d[c];
  end

endmodule

// File: tb/tb_lfsr_bank.sv
// Testbench for lfsr_bank: default instance plus an N_CH=3/STEPS=3 instance,
// checked every cycle against a behavioural model, with literal anchors.
module tb_lfsr_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic        out_ready;
  logic        seed_we;
  logic [1:0]  seed_ch;
  logic [15:0] seed_data;

  logic        va, vb, la, lb;
  logic [63:0] qa;
  logic [47:0] qb;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  lfsr_bank u_a (
    .clk(clk), .rst(rst), .en(en), .out_ready(out_ready), .out_valid(va), .q(qa),
    .seed_we(seed_we), .seed_ch(seed_ch), .seed_data(seed_data), .lockup(la)
  );

  lfsr_bank #(.N_CH(3), .STEPS(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .out_ready(out_ready), .out_valid(vb), .q(qb),
    .seed_we(seed_we), .seed_ch(seed_ch), .seed_data(seed_data), .lockup(lb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rules: default seed and single shift expressed arithmetically
  function automatic logic [15:0] m_ds(input int c);
    logic [31:0] p;
    logic [15:0] r;
    p = 32'(c) * 32'h9E37;
    r = 16'h632C ^ p[15:0];
    if (r == 16'h0) r = 16'h632C;
    return r;
  endfunction

  function automatic logic [15:0] m_adv(input logic [15:0] x);
    int fb;
    fb = $countones(x & 16'hD008) % 2;
    return 16'((32'(x) * 2 + fb) % 65536);
  endfunction

  // Model: per instance, channel values, word-valid flag, shifts still owed
  logic [15:0] m_d [2][4];
  bit          m_v [2];
  bit          m_lk [2];
  int          m_pend [2];

  task automatic model_step(input int i);
    int n, st;
    n  = (i == 0) ? 4 : 3;
    st = (i == 0) ? 1 : 3;
    if (rst) begin
      for (int c = 0; c < 4; c++) m_d[i][c] = m_ds(c);
      m_v[i] = 0; m_pend[i] = 0; m_lk[i] = 0;
    end else begin
      if (m_pend[i] > 0) begin
        for (int c = 0; c < n; c++) m_d[i][c] = m_adv(m_d[i][c]);
        m_pend[i]--;
        if (m_pend[i] == 0) m_v[i] = en;
      end else if (m_v[i]) begin
        if (out_ready) begin
          m_v[i] = 0;
          m_pend[i] = st;
        end else if (!en) begin
          m_v[i] = 0;
        end
      end else begin
        m_v[i] = en;
      end
      m_lk[i] = 0;
      if (seed_we && int'(seed_ch) < n) begin
        m_d[i][seed_ch] = (seed_data != 16'h0) ? seed_data : m_ds(int'(seed_ch));
        m_lk[i] = (seed_data == 16'h0);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_valid", 16'(va), 16'(m_v[0]));
      chk("a_lockup", 16'(la), 16'(m_lk[0]));
      chk("b_valid", 16'(vb), 16'(m_v[1]));
      chk("b_lockup", 16'(lb), 16'(m_lk[1]));
      for (int c = 0; c < 4; c++) chk($sformatf("a_q_ch%0d", c), qa[c*16 +: 16], m_d[0][c]);
      for (int c = 0; c < 3; c++) chk($sformatf("b_q_ch%0d", c), qb[c*16 +: 16], m_d[1][c]);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] exp_q  [5] = '{16'h632C, 16'h632C, 16'hC658, 16'hC658, 16'h8CB1};
  bit          exp_va [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  bit          exp_vb [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    seed_we = 1'b0; seed_ch = 2'd0; seed_data = 16'h0;
    tick(); tick();
    chk_en = 1;

    // Reset state and default seeds
    chk("rst_valid", 16'(va), 16'h0);
    chk("rst_lockup", 16'(la), 16'h0);
    chk("rst_ch0", qa[15:0], 16'h632C);
    chk("rst_ch1", qa[31:16], 16'hFD1B);
    chk("rst_ch2", qa[47:32], 16'h5F42);
    chk("rst_ch3", qa[63:48], 16'hB989);
    chk("model_ds3", m_ds(3), 16'hB989);

    // Free-running words with ready held high
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t1_valid_%0d", k), 16'(va), 16'(exp_va[k]));
      chk($sformatf("t1_ch0_%0d", k), qa[15:0], exp_q[k]);
      chk($sformatf("t3_valid_%0d", k), 16'(vb), 16'(exp_vb[k]));
    end
    chk("t3_next_word", qb[15:0], 16'h1963);
    chk("model_8cb1", m_d[0][0], 16'h8CB1);

    // Backpressure holds the first word
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t2_valid", 16'(va), 16'h1);
      chk("t2_ch0", qa[15:0], 16'h632C);
    end

    // Seed write during HOLD
    seed_we = 1'b1; seed_ch = 2'd2; seed_data = 16'hACE1;
    tick();
    seed_we = 1'b0;
    chk("t4_ch2", qa[47:32], 16'hACE1);
    chk("t4_ch0", qa[15:0], 16'h632C);
    chk("t4_ch1", qa[31:16], 16'hFD1B);
    chk("t4_ch3", qa[63:48], 16'hB989);
    chk("t4_valid", 16'(va), 16'h1);
    chk("t4_lockup", 16'(la), 16'h0);
    chk("t4_b_ch2", qb[47:32], 16'hACE1);

    // Zero seed recovers the default and pulses lockup once
    seed_we = 1'b1; seed_ch = 2'd2; seed_data = 16'h0;
    tick();
    seed_we = 1'b0;
    chk("t5_ch2", qa[47:32], 16'h5F42);
    chk("t5_lockup", 16'(la), 16'h1);
    tick();
    chk("t5_lockup_end", 16'(la), 16'h0);
    chk("t5_valid", 16'(va), 16'h1);

    // Channel 3: in range for the 4-channel bank, out of range for the 3-channel one
    seed_we = 1'b1; seed_ch = 2'd3; seed_data = 16'h0;
    tick();
    seed_we = 1'b0;
    chk("t5_a_lockup", 16'(la), 16'h1);
    chk("t5_oor_lockup", 16'(lb), 16'h0);
    chk("t5_oor_ch0", qb[15:0], 16'h632C);
    chk("t5_oor_ch1", qb[31:16], 16'hFD1B);
    chk("t5_oor_ch2", qb[47:32], 16'h5F42);
    tick();

    // en low in HOLD drops valid and freezes q
    en = 1'b0;
    tick();
    chk("t6_valid", 16'(va), 16'h0);
    chk("t6_ch0", qa[15:0], 16'h632C);
    tick();
    chk("t6_ch0_frozen", qa[15:0], 16'h632C);

    // Reset in the middle of a 3-step shift
    en = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t6_b_shifting", 16'(vb), 16'h0);
    chk("t6_b_one_shift", qb[15:0], 16'hC658);
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", 16'(vb), 16'h0);
    chk("t6_rst_ch0", qb[15:0], 16'h632C);
    chk("t6_rst_ch1", qb[31:16], 16'hFD1B);
    chk("t6_rst_lockup", 16'(lb), 16'h0);
    rst = 1'b0;
    tick();
    chk("t6_restart_valid", 16'(vb), 16'h1);
    chk("t6_restart_ch0", qb[15:0], 16'h632C);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      en        = ($urandom_range(0, 7) != 0);
      out_ready = 1'($urandom_range(0, 1));
      seed_we   = ($urandom_range(0, 15) == 0);
      seed_ch   = 2'($urandom_range(0, 3));
      seed_data = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; seed_we = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
